// File: rtl/pipe_ctrl.sv
// Hazard and stall controller for the 5-stage core: drives PC and inter-stage bank enables/flushes,
// tracks multi-cycle multiply occupancy of EX, and counts PC-stall cycles.
module pipe_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic                  ex_is_mul,
  input  logic                  ex_branch_taken,
  input  logic                  icache_ready,
  input  logic                  mem_dcache_req,
  input  logic                  dcache_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_en,
  output logic                  mem_wb_flush,
  output logic                  mul_busy,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic {
    MUL_IDLE,
    MUL_BUSY
  } mul_state_t;

  // The first MUL cycle is spent in MUL_IDLE, so the counter starts two below the latency.
  localparam bit         MUL_MULTI = (MUL_LATENCY > 1);
  localparam logic [3:0] MCNT_INIT = MUL_MULTI ? 4'(MUL_LATENCY - 2) : 4'd0;

  mul_state_t state, state_next;
  logic [3:0] mcnt, mcnt_next;
  logic       dstall, mstall, istall, lu_hz;

  assign dstall = mem_dcache_req & ~dcache_ready;
  assign istall = ~icache_ready;
  assign lu_hz  = ex_is_load & ex_reg_write & (ex_rd != '0) &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  assign mul_busy = (state == MUL_BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MUL_IDLE;
      mcnt  <= 4'd0;
    end else begin
      state <= state_next;
      mcnt  <= mcnt_next;
    end
  end

  // A D-cache stall freezes the multiplier but still holds the MUL in EX.
  always_comb begin
    state_next = state;
    mcnt_next  = mcnt;
    mstall     = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (ex_is_mul && MUL_MULTI) begin
          mstall = 1'b1;
          if (!dstall) begin
            state_next = MUL_BUSY;
            mcnt_next  = MCNT_INIT;
          end
        end
      end
      MUL_BUSY: begin
        if (dstall) begin
          mstall = 1'b1;
        end else if (mcnt != 4'd0) begin
          mstall    = 1'b1;
          mcnt_next = mcnt - 4'd1;
        end else begin
          state_next = MUL_IDLE;
        end
      end
      default: begin
        state_next = MUL_IDLE;
        mcnt_next  = 4'd0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_en    = 1'b0;
      ex_mem_flush = 1'b1;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (dstall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mstall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (lu_hz) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end else if (istall) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each cycle checks the packed control vector, mul_busy and the
// stall counter against hand-derived expectations (CNT_W=4 so saturation is reachable).
module tb_pipe_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_reg_write, ex_is_load, ex_is_mul;
  logic       ex_branch_taken, icache_ready, mem_dcache_req, dcache_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mul_busy;
  logic [3:0] stall_cnt;

  int checkCount = 0;
  int failCount  = 0;
  int expCnt     = 0;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush}
  localparam logic [8:0] C_NORM   = 9'b110101010;
  localparam logic [8:0] C_RST    = 9'b001010101;
  localparam logic [8:0] C_DSTALL = 9'b000000011;
  localparam logic [8:0] C_MSTALL = 9'b000001110;
  localparam logic [8:0] C_BRANCH = 9'b111111010;
  localparam logic [8:0] C_LU     = 9'b000111010;
  localparam logic [8:0] C_ISTALL = 9'b011101010;

  logic [8:0] ctrl;
  assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                 ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush};

  pipe_ctrl #(.MUL_LATENCY(4), .REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_is_mul(ex_is_mul),
    .ex_branch_taken(ex_branch_taken), .icache_ready(icache_ready),
    .mem_dcache_req(mem_dcache_req), .dcache_ready(dcache_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .mul_busy(mul_busy), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic setIdle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_reg_write = 0; ex_is_load = 0; ex_is_mul = 0;
    ex_branch_taken = 0; icache_ready = 1; mem_dcache_req = 0; dcache_ready = 1;
  endtask

  // Checks one cycle mid-period, then advances past the next rising edge and updates expCnt.
  task automatic applyStimulus(input string tag, input logic [8:0] expCtrl, input logic expBusy);
    @(negedge clk);
    checkOutput({tag, " ctrl"}, 32'(ctrl), 32'(expCtrl));
    checkOutput({tag, " mul_busy"}, 32'(mul_busy), 32'(expBusy));
    checkOutput({tag, " stall_cnt"}, 32'(stall_cnt), 32'(expCnt));
    if (reset) expCnt = 0;
    else if (!expCtrl[8] && expCnt != 15) expCnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    setIdle();
    reset = 1;
    for (int i = 0; i < 3; i++) applyStimulus("reset", C_RST, 0);
    reset = 0;
    applyStimulus("post_reset", C_NORM, 0);

    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1;
    applyStimulus("lu_rs2", C_LU, 0);
    id_uses_rs2 = 0; id_rs1 = 5'd5; id_uses_rs1 = 0;
    applyStimulus("lu_rs1_unused", C_NORM, 0);
    id_uses_rs1 = 1;
    applyStimulus("lu_rs1", C_LU, 0);
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1;
    applyStimulus("lu_x0", C_NORM, 0);
    setIdle();

    reset = 1;
    applyStimulus("reset2", C_RST, 0);
    reset = 0;

    ex_is_mul = 1;
    applyStimulus("mul_c1", C_MSTALL, 0);
    applyStimulus("mul_c2", C_MSTALL, 1);
    applyStimulus("mul_c3", C_MSTALL, 1);
    applyStimulus("mul_c4", C_NORM, 1);
    ex_is_mul = 0;
    applyStimulus("mul_done", C_NORM, 0);

    ex_is_mul = 1;
    applyStimulus("dmul_c1", C_MSTALL, 0);
    applyStimulus("dmul_c2", C_MSTALL, 1);
    mem_dcache_req = 1; dcache_ready = 0;
    for (int i = 0; i < 5; i++) applyStimulus("dmul_dstall", C_DSTALL, 1);
    dcache_ready = 1;
    applyStimulus("dmul_c3", C_MSTALL, 1);
    applyStimulus("dmul_c4", C_NORM, 1);
    ex_is_mul = 0; mem_dcache_req = 0;
    applyStimulus("dmul_done", C_NORM, 0);

    ex_branch_taken = 1; icache_ready = 0;
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1;
    applyStimulus("branch", C_BRANCH, 0);
    setIdle();
    applyStimulus("after_branch", C_NORM, 0);

    icache_ready = 0;
    for (int i = 0; i < 20; i++) applyStimulus("istall", C_ISTALL, 0);
    checkOutput("stall_cnt_sat", 32'(stall_cnt), 32'd15);
    setIdle();
    applyStimulus("final", C_NORM, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
